// File: rtl/lcd_pkg.sv
// lcd_pkg: command-word layout, HD44780 init commands and sequencer states
package lcd_pkg;
  localparam int SRC_BIT = 10;
  localparam int RW_BIT = 9;
  localparam int RS_BIT = 8;
  localparam logic [10:0] IDLE_WORD = 11'(1 << RW_BIT);
  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON = 8'h0C;
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_ENTRY = 8'h06;
  localparam logic [7:0] CMD_DDRAM0 = 8'h80;
  typedef enum logic [2:0] {S_POWER, S_INIT, S_ADDR, S_DATA, S_IDLE} state_t;
  function automatic logic [10:0] cmd_word(input logic [7:0] c);
    logic [10:0] w;
    w = '0;
    w[7:0] = c;
    return w;
  endfunction
  function automatic logic [10:0] data_word(input logic [7:0] i);
    logic [10:0] w;
    w = '0;
    w[SRC_BIT] = 1'b1;
    w[RS_BIT] = 1'b1;
    w[7:0] = i;
    return w;
  endfunction
endpackage

// File: rtl/wait_counter.sv
// wait_counter: idle-cycle counter with clear; done marks the last cycle of a len-cycle wait
module wait_counter #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [CNT_W-1:0] len,
  output logic             done
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clr ? '0 : cnt + 1'b1;
  assign done = (len == '0) || (cnt == len - 1'b1);
endmodule

// File: rtl/lcd_sequencer.sv
// lcd_sequencer: HD44780 power-on/init sequence, then periodic DDRAM refresh from the data bank
module lcd_sequencer
  import lcd_pkg::*;
#(
  parameter int SIZE = 4,
  parameter int CNT_W = 20,
  parameter int POWER_WAIT = 750000,
  parameter int CMD_WAIT = 2000,
  parameter int CLEAR_WAIT = 82000,
  parameter int REFRESH_WAIT = 500000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_refresh,
  output logic [10:0] o_comm,
  output logic        o_ready,
  output logic        o_busy
);
  state_t state;
  logic [8:0] idx;
  logic issue, pending, last_clear, done, start;
  logic [CNT_W-1:0] len;
  logic [7:0] init_cmd;
  // issue: the wait after the previous word has elapsed, next active word goes out on this edge
  always_comb begin
    len = state == S_POWER ? CNT_W'(POWER_WAIT) :
          state == S_IDLE ? CNT_W'(REFRESH_WAIT) :
          last_clear ? CNT_W'(CLEAR_WAIT) : CNT_W'(CMD_WAIT);
    init_cmd = idx[1:0] == 2'd0 ? CMD_FUNC_SET :
               idx[1:0] == 2'd1 ? CMD_DISP_ON :
               idx[1:0] == 2'd2 ? CMD_CLEAR : CMD_ENTRY;
    start = state == S_ADDR ? issue :
            state == S_DATA ? issue && idx == 9'(SIZE) && (pending || i_refresh) :
            state == S_IDLE && (i_refresh || done);
  end
  wait_counter #(.CNT_W(CNT_W)) u_wait (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .clr  (issue || done || start),
    .len  (len),
    .done (done)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= S_POWER;
      idx <= '0;
      issue <= 1'b0;
      pending <= 1'b0;
      last_clear <= 1'b0;
      o_comm <= IDLE_WORD;
      o_ready <= 1'b0;
      o_busy <= 1'b1;
    end else begin
      o_comm <= IDLE_WORD;
      if (start && state == S_DATA) pending <= 1'b0;
      else if (state != S_IDLE && i_refresh) pending <= 1'b1;
      if (start) begin
        o_comm <= cmd_word(CMD_DDRAM0);
        o_ready <= 1'b1;
        o_busy <= 1'b1;
        state <= S_DATA;
        idx <= '0;
        issue <= CMD_WAIT == 0;
        last_clear <= 1'b0;
      end else if (issue) begin
        if (state == S_INIT) begin
          o_comm <= cmd_word(init_cmd);
          idx <= idx + 9'd1;
          last_clear <= init_cmd == CMD_CLEAR;
          issue <= (init_cmd == CMD_CLEAR ? CLEAR_WAIT : CMD_WAIT) == 0;
          if (idx[1:0] == 2'd3) state <= S_ADDR;
        end else if (idx == 9'(SIZE)) begin
          state <= S_IDLE;
          o_busy <= 1'b0;
          issue <= 1'b0;
        end else begin
          o_comm <= data_word(idx[7:0]);
          idx <= idx + 9'd1;
          issue <= CMD_WAIT == 0;
        end
      end else if (done) begin
        issue <= 1'b1;
        if (state == S_POWER) state <= S_INIT;
      end
    end
endmodule

// File: doc/lcd_sequencer.md
Name: lcd_sequencer

Overview:
Command/data sequencer directly upstream of the LCD display stage; drives its 11-bit command word every clock.
After reset it runs the HD44780 power-on wait and init sequence. It then refreshes the panel periodically: it sets the DDRAM address and streams SIZE data-bank bytes by index.
The display stage writes once per clock, so the sequencer emits a harmless busy-flag-read word on every non-active cycle.

Parameters:
SIZE, 4, number of data-bank bytes written per refresh (multiple of 4, max 256)
CNT_W, 20, width of the wait counter
POWER_WAIT, 750000, idle cycles after reset before the first init word (15 ms at 50 MHz)
CMD_WAIT, 2000, idle cycles after every active word except clear (40 us)
CLEAR_WAIT, 82000, idle cycles after the clear-display word (1.64 ms)
REFRESH_WAIT, 500000, idle cycles between automatic refreshes

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_refresh  in  1  single-cycle request for an immediate refresh
o_comm  out  11  command word: [10] source (0 = byte in [7:0], 1 = data-bank byte at index [7:0]), [9] RW, [8] RS, [7:0] command byte or index
o_ready  out  1  high once the init sequence has completed
o_busy  out  1  high while an init or refresh sequence is in progress

Interface (already decided):
- One clock, i_clk.
- Reset i_rst_n is asynchronous and active-low.

Behaviour:
- Word encodings:
  - IDLE word = 11'h200 (RW=1, RS=0: busy-flag read, no side effect).
  - Command word = {1'b0, 2'b00, cmd}.
  - Data word = {1'b1, 2'b01, idx}.
- Reset (asynchronous, any state): o_comm=IDLE, o_ready=0, o_busy=1, state=S_POWER, counter=0, pending=0.
- All outputs are registered; no combinational path from i_refresh to o_comm.
- Step rule: each active word is driven for exactly 1 cycle, then IDLE for W cycles.
  - W = CLEAR_WAIT after 8'h01; otherwise CMD_WAIT.
  - Consecutive active words are therefore W+1 cycles apart.
- States and transitions:
  - S_POWER: IDLE for POWER_WAIT cycles counted from the first rising edge with i_rst_n high, then go to S_INIT.
  - S_INIT: issue 8'h38, 8'h0C, 8'h01, 8'h06 in that order, then go to S_ADDR. o_ready rises the cycle after the 8'h06 wait ends.
  - S_ADDR: issue 8'h80 (DDRAM address 0), then go to S_DATA.
  - S_DATA: issue data words idx = 0..SIZE-1, then go to S_IDLE.
  - S_IDLE: o_busy=0, o_comm=IDLE; the counter counts REFRESH_WAIT and then goes to S_ADDR.
- i_refresh handling:
  - In S_IDLE: go to S_ADDR on the next cycle and clear the counter.
  - In S_POWER/S_INIT/S_ADDR/S_DATA: set pending. When the sequence reaches S_IDLE with pending set, clear pending and go straight to S_ADDR with no wait.
  - Multiple requests while busy collapse into one pending refresh.
  - If i_refresh arrives in the same cycle the REFRESH_WAIT expiry triggers a refresh, exactly one refresh starts.
- Counter: compare against the wait value minus 1; it never wraps. Wait values of 0 mean back-to-back active words.
- o_busy = 1 in every state except S_IDLE.

Decomposition:
- Package lcd_pkg holds:
  - the IDLE word and field positions (SRC=10, RW=9, RS=8);
  - init command constants CMD_FUNC_SET=8'h38, CMD_DISP_ON=8'h0C, CMD_CLEAR=8'h01, CMD_ENTRY=8'h06, CMD_DDRAM0=8'h80;
  - state encodings.
- One sub-module, wait_counter (CNT_W): load/clear, terminal-count pulse, shared by all states.

Test Plan:
All scenarios use the overrides POWER_WAIT=4, CMD_WAIT=2, CLEAR_WAIT=3, REFRESH_WAIT=10, SIZE=4.
- Reset release: o_comm = 11'h200 for cycles 0-3; 11'h038 at cycle 4; 11'h00C at 7; 11'h001 at 10; 11'h006 at 14; o_ready=1 at cycle 17.
- First refresh: 11'h080, then 11'h500, 11'h501, 11'h502, 11'h503, each spaced 3 cycles apart; o_busy falls after the last wait; no wait occurs after 11'h080 beyond CMD_WAIT.
- Periodic refresh: in S_IDLE with no i_refresh, 11'h080 reappears exactly 10 idle cycles after o_busy falls.
- i_refresh in S_IDLE at idle cycle 3 -> 11'h080 on the next cycle; the counter restarts afterwards.
- Three i_refresh pulses during S_DATA -> exactly one extra refresh follows immediately after the current one ends.
- i_rst_n low mid-S_DATA -> o_comm=11'h200, o_ready=0, o_busy=1 the same cycle; the full init sequence replays after release.
